// File: rtl/spad_scan_fsm_if.sv
// rtl/spad_scan_fsm_if.sv - readout FIFO write port between the scan FSM and the FIFO
interface spad_scan_fsm_if #(
    parameter int DOUT_W = 16
);
    logic [DOUT_W-1:0] dout;
    logic              req_fifowr;
    logic              fifo_full;

    modport master (output dout, output req_fifowr, input fifo_full);
    modport slave  (input dout, input req_fifowr, output fifo_full);
endinterface

// File: rtl/spad_scan_fsm.sv
// rtl/spad_scan_fsm.sv - SPAD frame sequencer: clear, laser-gated exposure, ROI scan into readout FIFO
module spad_scan_fsm #(
    parameter int ADDR_W        = 6,
    parameter int PIX_W         = 3,
    parameter int DIN_W         = 5,
    parameter int DOUT_W        = 16,
    parameter int WIN_W         = 8,
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int FCNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    pll_locked,
    input  logic                    spad_on_clk,
    input  logic [WIN_W-1:0]        window_cycles,
    input  logic [ADDR_W+PIX_W:0]   roi_first,
    input  logic [ADDR_W+PIX_W:0]   roi_last,
    input  logic                    skip_zero,
    input  logic                    single_shot,
    input  logic [DIN_W-1:0]        DIN,
    output logic                    PROBE_SEL,
    output logic [ADDR_W-1:0]       ADDR,
    output logic [PIX_W-1:0]        PIX_SEL,
    output logic                    MEM_CLEAR,
    output logic                    READ_EN,
    output logic                    SPAD_ON_CLK_EN,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    lock_lost,
    output logic [FCNT_W-1:0]       frame_cnt,
    spad_scan_fsm_if.master         fifo
);
    localparam int IW = 1 + ADDR_W + PIX_W;
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    if (DOUT_W < IW + DIN_W) begin : g_width_check
        $error("spad_scan_fsm: DOUT_W too small for {index, DIN}");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_WAIT_EDGE, S_EXPOSE, S_READ,
        S_SETTLE, S_CAPTURE, S_STALL, S_DONE
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     last_lat;
    logic [WIN_W-1:0]  win_lat;
    logic [WIN_W-1:0]  edge_cnt;
    logic [CW-1:0]     clr_cnt;
    logic [SW-1:0]     settle_cnt;
    logic              sync1, sync2, sync3;
    logic              spad_edge;
    // single-shot re-arm: set whenever en is seen low, consumed at frame start
    logic              armed;
    logic [DOUT_W-1:0] word;

    assign {PROBE_SEL, ADDR, PIX_SEL} = idx;
    assign spad_edge = sync2 & ~sync3;

    always_comb begin
        word = '0;
        word[DIN_W-1:0] = DIN;
        word[DOUT_W-1 -: IW] = idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            idx             <= '0;
            last_lat        <= '0;
            win_lat         <= '0;
            edge_cnt        <= '0;
            clr_cnt         <= '0;
            settle_cnt      <= '0;
            sync1           <= 1'b0;
            sync2           <= 1'b0;
            sync3           <= 1'b0;
            armed           <= 1'b1;
            MEM_CLEAR       <= 1'b0;
            READ_EN         <= 1'b0;
            SPAD_ON_CLK_EN  <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            lock_lost       <= 1'b0;
            frame_cnt       <= '0;
            fifo.dout       <= '0;
            fifo.req_fifowr <= 1'b0;
        end else begin
            sync1           <= spad_on_clk;
            sync2           <= sync1;
            sync3           <= sync2;
            frame_done      <= 1'b0;
            lock_lost       <= 1'b0;
            READ_EN         <= 1'b0;
            fifo.req_fifowr <= 1'b0;
            if (!en) armed <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (en && pll_locked && (!single_shot || armed)) begin
                        state     <= S_CLEAR;
                        MEM_CLEAR <= 1'b1;
                        clr_cnt   <= '0;
                        win_lat   <= (window_cycles == '0) ? WIN_W'(1) : window_cycles;
                        armed     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
                        MEM_CLEAR <= 1'b0;
                        state     <= S_WAIT_EDGE;
                    end
                end
                S_WAIT_EDGE, S_EXPOSE: begin
                    if (!pll_locked) begin
                        SPAD_ON_CLK_EN <= 1'b0;
                        lock_lost      <= 1'b1;
                        busy           <= 1'b0;
                        state          <= S_IDLE;
                    end else if (spad_edge) begin
                        if (state == S_WAIT_EDGE) begin
                            SPAD_ON_CLK_EN <= 1'b1;
                            edge_cnt       <= '0;
                            state          <= S_EXPOSE;
                        end else if (edge_cnt == win_lat - 1'b1) begin
                            SPAD_ON_CLK_EN <= 1'b0;
                            READ_EN        <= 1'b1;
                            state          <= S_READ;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    idx        <= roi_first;
                    last_lat   <= (roi_last < roi_first) ? roi_first : roi_last;
                    settle_cnt <= '0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state <= S_CAPTURE;
                end
                S_CAPTURE, S_STALL: begin
                    if (state == S_CAPTURE) fifo.dout <= word;
                    if (state == S_CAPTURE && skip_zero && DIN == '0) begin
                        fifo.dout <= fifo.dout;
                    end else if (fifo.fifo_full) begin
                        state <= S_STALL;
                    end else begin
                        fifo.req_fifowr <= 1'b1;
                    end
                    // advance once the word is written or suppressed
                    if ((state == S_CAPTURE && skip_zero && DIN == '0) || !fifo.fifo_full) begin
                        if (idx == last_lat) begin
                            state <= S_DONE;
                        end else begin
                            idx        <= idx + 1'b1;
                            settle_cnt <= '0;
                            state      <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 1'b1;
                    if (!single_shot && en && pll_locked) begin
                        state     <= S_CLEAR;
                        MEM_CLEAR <= 1'b1;
                        clr_cnt   <= '0;
                        win_lat   <= (window_cycles == '0) ? WIN_W'(1) : window_cycles;
                        armed     <= 1'b0;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spad_scan_fsm.sv
// tb/tb_spad_scan_fsm.sv - scoreboard bench for spad_scan_fsm
module tb_spad_scan_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       pll_locked = 1'b0;
    logic       spad_on_clk = 1'b0;
    logic [7:0] window_cycles = '0;
    logic [9:0] roi_first = '0;
    logic [9:0] roi_last = '0;
    logic       skip_zero = 1'b0;
    logic       single_shot = 1'b0;
    logic [4:0] DIN;
    logic       PROBE_SEL, MEM_CLEAR, READ_EN, SPAD_ON_CLK_EN, busy, frame_done, lock_lost;
    logic [5:0] ADDR;
    logic [2:0] PIX_SEL;
    logic [15:0] frame_cnt;

    spad_scan_fsm_if #(.DOUT_W(16)) fifo_if ();

    spad_scan_fsm dut (
        .clk(clk), .rst(rst), .en(en), .pll_locked(pll_locked), .spad_on_clk(spad_on_clk),
        .window_cycles(window_cycles), .roi_first(roi_first), .roi_last(roi_last),
        .skip_zero(skip_zero), .single_shot(single_shot), .DIN(DIN),
        .PROBE_SEL(PROBE_SEL), .ADDR(ADDR), .PIX_SEL(PIX_SEL), .MEM_CLEAR(MEM_CLEAR),
        .READ_EN(READ_EN), .SPAD_ON_CLK_EN(SPAD_ON_CLK_EN), .busy(busy),
        .frame_done(frame_done), .lock_lost(lock_lost), .frame_cnt(frame_cnt),
        .fifo(fifo_if)
    );

    logic [4:0] din_tab [1024];
    assign DIN = din_tab[{PROBE_SEL, ADDR, PIX_SEL}];

    initial forever #10 clk = ~clk;
    initial begin
        #3;
        forever #50 spad_on_clk = ~spad_on_clk;
    end

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q [$];
    int wr_count = 0;
    int done_cnt = 0;
    int exp_frames = 0;
    int exp_win = 1;
    bit skip_win = 0;
    int mem_run = 0;
    int spad_total = 0;
    int spad_base = 0;
    logic spad_en_prev = 1'b0;
    logic full_prev = 1'b0;
    bit rand_full = 0;
    int hold_at = -1;
    int hold_gen = 0;
    int hold_gen_seen = 0;
    int hold_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge spad_on_clk) if (SPAD_ON_CLK_EN) spad_total++;
    always @(posedge clk) full_prev = fifo_if.fifo_full;

    always @(negedge clk) begin
        if (hold_gen != hold_gen_seen && wr_count >= hold_at) begin
            hold_gen_seen = hold_gen;
            hold_cnt = 10;
        end
        if (hold_cnt > 0) begin
            fifo_if.fifo_full = 1'b1;
            hold_cnt--;
        end else begin
            fifo_if.fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // monitor: pops the scoreboard on every FIFO write and checks frame-level timing
    always @(negedge clk) begin
        if (rst) begin
            if (fifo_if.req_fifowr) begin
                wr_count++;
                check("write_while_full", full_prev, 0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: dout=0x%0h with no word expected", fifo_if.dout);
                end else begin
                    check("dout", fifo_if.dout, exp_q.pop_front());
                end
            end
            if (MEM_CLEAR) mem_run++;
            else if (mem_run != 0) begin
                check("mem_clear_len", mem_run, 4);
                mem_run = 0;
            end
            if (!spad_en_prev && SPAD_ON_CLK_EN) spad_base = spad_total;
            if (spad_en_prev && !SPAD_ON_CLK_EN && !skip_win)
                check("expose_edges", spad_total - spad_base, exp_win);
            spad_en_prev = SPAD_ON_CLK_EN;
            if (frame_done) done_cnt++;
        end
    end

    task automatic push_frame(input int first, input int last, input bit skip);
        int le;
        le = (last < first) ? first : last;
        for (int i = first; i <= le; i++)
            if (!(skip && din_tab[i] == 0)) exp_q.push_back(16'(i * 64 + int'(din_tab[i])));
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
        check("frame_start", busy, 1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 30000 && done_cnt < target; i++) @(negedge clk);
        check("frame_done_seen", done_cnt >= target, 1);
    endtask

    task automatic run_frame(input int first, input int last, input bit skip, input int win, input bit keep_en);
        int d0;
        @(negedge clk);
        roi_first = 10'(first);
        roi_last = 10'(last);
        skip_zero = skip;
        window_cycles = 8'(win);
        exp_win = (win == 0) ? 1 : win;
        push_frame(first, last, skip);
        d0 = done_cnt;
        en = 1'b1;
        wait_busy();
        if (!keep_en) en = 1'b0;
        wait_done(d0 + 1);
        exp_frames++;
        check("frame_cnt", frame_cnt, exp_frames);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        if (!keep_en || single_shot) check("idle_after_frame", busy, 0);
    endtask

    task automatic fill_random(input int zero_odds);
        for (int i = 0; i < 1024; i++)
            din_tab[i] = ($urandom_range(0, zero_odds) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endtask

    initial begin
        int d0, busy_seen, first, last;
        for (int i = 0; i < 1024; i++) din_tab[i] = 5'b10011;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {PROBE_SEL, ADDR, PIX_SEL, MEM_CLEAR, READ_EN, SPAD_ON_CLK_EN,
                                fifo_if.dout, fifo_if.req_fifowr, busy, frame_done, lock_lost, frame_cnt}, 0);
        rst = 1'b1;
        pll_locked = 1'b1;

        run_frame(0, 1023, 0, 2, 0);

        for (int i = 0; i < 1024; i++) din_tab[i] = 5'(i % 31 + 1);
        din_tab[6] = 5'd0;
        d0 = wr_count;
        run_frame(5, 8, 1, 1, 0);
        check("skip_write_count", wr_count - d0, 3);

        fill_random(1000);
        hold_at = wr_count + 2;
        hold_gen++;
        d0 = wr_count;
        run_frame(20, 25, 0, 3, 0);
        check("stall_write_count", wr_count - d0, 6);

        // lock loss during exposure
        @(negedge clk);
        window_cycles = 8'd3;
        exp_win = 3;
        d0 = wr_count;
        en = 1'b1;
        for (int i = 0; i < 200 && !SPAD_ON_CLK_EN; i++) @(negedge clk);
        check("expose_reached", SPAD_ON_CLK_EN, 1);
        en = 1'b0;
        skip_win = 1;
        pll_locked = 1'b0;
        @(negedge clk);
        check("lock_gate_off", SPAD_ON_CLK_EN, 0);
        check("lock_lost_pulse", lock_lost, 1);
        check("lock_busy", busy, 0);
        @(negedge clk);
        check("lock_lost_once", lock_lost, 0);
        check("lock_frame_cnt", frame_cnt, exp_frames);
        check("lock_no_writes", wr_count - d0, 0);
        pll_locked = 1'b1;
        @(negedge clk);
        skip_win = 0;

        // single shot: en held high gives exactly one frame until en toggles
        single_shot = 1'b1;
        fill_random(5);
        run_frame(100, 110, 1, 2, 1);
        busy_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("single_shot_no_refire", busy_seen, 0);
        en = 1'b0;
        @(negedge clk);
        run_frame(100, 110, 1, 2, 1);
        check("single_shot_cnt", frame_cnt, exp_frames);
        en = 1'b0;
        single_shot = 1'b0;

        // continuous: back-to-back frames while en is high
        @(negedge clk);
        roi_first = 10'd300;
        roi_last = 10'd310;
        skip_zero = 1'b1;
        window_cycles = 8'd1;
        exp_win = 1;
        push_frame(300, 310, 1);
        push_frame(300, 310, 1);
        d0 = done_cnt;
        en = 1'b1;
        wait_done(d0 + 1);
        en = 1'b0;
        exp_frames++;
        check("cont_frame_cnt1", frame_cnt, exp_frames);
        check("cont_still_busy", busy, 1);
        wait_done(d0 + 2);
        exp_frames++;
        check("cont_frame_cnt2", frame_cnt, exp_frames);
        check("cont_queue_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check("cont_idle", busy, 0);

        // randomized frames with random backpressure
        rand_full = 1;
        for (int f = 0; f < 6; f++) begin
            fill_random(3);
            first = $urandom_range(0, 1023);
            if ($urandom_range(0, 4) == 0) last = $urandom_range(0, first);
            else last = (first + $urandom_range(0, 40) > 1023) ? 1023 : first + $urandom_range(0, 40);
            run_frame(first, last, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
        end
        rand_full = 0;

        // reset mid-scan, then a clean frame from CLEAR
        fill_random(1000);
        @(negedge clk);
        roi_first = 10'd0;
        roi_last = 10'd63;
        skip_zero = 1'b0;
        window_cycles = 8'd2;
        exp_win = 2;
        push_frame(0, 63, 0);
        d0 = wr_count;
        en = 1'b1;
        for (int i = 0; i < 2000 && wr_count < d0 + 5; i++) @(negedge clk);
        check("scan_reached", wr_count >= d0 + 5, 1);
        rst = 1'b0;
        #1;
        check("midscan_reset_outputs", {PROBE_SEL, ADDR, PIX_SEL, MEM_CLEAR, READ_EN, SPAD_ON_CLK_EN,
                                        fifo_if.dout, fifo_if.req_fifowr, busy, frame_done, lock_lost, frame_cnt}, 0);
        exp_q.delete();
        exp_frames = 0;
        mem_run = 0;
        spad_en_prev = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        push_frame(0, 63, 0);
        d0 = done_cnt;
        for (int i = 0; i < 5 && !MEM_CLEAR; i++) @(negedge clk);
        check("restart_clear", MEM_CLEAR, 1);
        en = 1'b0;
        wait_done(d0 + 1);
        exp_frames++;
        check("restart_frame_cnt", frame_cnt, exp_frames);
        check("restart_queue_drained", exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spad_scan_fsm.md
Name: spad_scan_fsm

Overview:
- Parametrised successor to the SPAD array readout FSM.
- Sequences each frame: memory clear, laser-synchronous exposure gating over a programmable number of spad_on_clk windows, then read request.
- Then scans a programmable region of interest (ROI) of pixel addresses and packs {address, data} words into the readout FIFO.
- Adds ROI scanning, zero-pixel suppression, single-shot/continuous modes and FIFO backpressure.

Parameters:
- ADDR_W, 6, width of ADDR bus to IC
- PIX_W, 3, width of PIX_SEL bus to IC
- DIN_W, 5, width of pixel data from IC
- DOUT_W, 16, FIFO word width; must be >= 1+ADDR_W+PIX_W+DIN_W (elaboration error otherwise)
- WIN_W, 8, width of window_cycles
- CLR_CYCLES, 4, cycles MEM_CLEAR is held high (>=1)
- SETTLE_CYCLES, 1, cycles between address change and DIN sample (>=1)
- FCNT_W, 16, frame counter width

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  frame enable.
- pll_locked  in  1  laser PLL lock.
- spad_on_clk  in  1  laser-synchronous clock, treated as data: 2-flop synchronised, rising-edge detected.
- window_cycles  in  WIN_W  exposure windows per frame; 0 treated as 1.
- roi_first  in  1+ADDR_W+PIX_W  first scan index {probe,addr,pix}.
- roi_last  in  1+ADDR_W+PIX_W  last scan index, inclusive.
- skip_zero  in  1  suppress FIFO writes for DIN==0.
- single_shot  in  1  one frame per en rising edge.
- fifo_full  in  1  FIFO backpressure.
- DIN  in  DIN_W  pixel data from IC.
- PROBE_SEL  out  1  scan index MSB.
- ADDR  out  ADDR_W  scan index middle field.
- PIX_SEL  out  PIX_W  scan index LSBs.
- MEM_CLEAR  out  1  global IC clear.
- READ_EN  out  1  IC read/latch request.
- SPAD_ON_CLK_EN  out  1  exposure gate.
- dout  out  DOUT_W  {PROBE_SEL,ADDR,PIX_SEL,zero pad,DIN}.
- req_fifowr  out  1  FIFO write strobe.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at frame end.
- lock_lost  out  1  one-cycle pulse on aborted exposure.
- frame_cnt  out  FCNT_W  completed frames; wraps.

Behaviour:
- Reset: all outputs registered and 0; scan index 0; state IDLE. Reset is honoured in any state and mid-frame.
- IDLE -> CLEAR when en && pll_locked. In single_shot mode this also requires en to have been seen low since the last frame.
- CLEAR: MEM_CLEAR=1 for exactly CLR_CYCLES cycles -> WAIT_EDGE.
- WAIT_EDGE: on the next synchronised spad_on_clk rising edge, SPAD_ON_CLK_EN=1 -> EXPOSE.
- EXPOSE: count spad_on_clk rising edges. On the edge that makes the count equal max(window_cycles,1), SPAD_ON_CLK_EN=0 -> READ.
  - window_cycles is sampled on entry to CLEAR; later changes are ignored for the frame.
- Lock loss: pll_locked==0 in WAIT_EDGE or EXPOSE -> SPAD_ON_CLK_EN=0 next cycle, lock_lost pulse, -> IDLE. No FIFO writes, frame_cnt unchanged.
- READ: READ_EN=1 for one cycle; scan index loaded from roi_first -> SETTLE.
- Scan index: index={PROBE_SEL,ADDR,PIX_SEL}, PIX_SEL fastest. roi_first/roi_last are sampled at READ. If roi_last<roi_first, only roi_first is read.
- SETTLE: hold address SETTLE_CYCLES cycles -> CAPTURE.
- CAPTURE: sample DIN.
  - If skip_zero && DIN==0: no write.
  - Else if fifo_full: -> STALL, holding dout.
  - Else req_fifowr=1 for one cycle with dout valid the same cycle.
- STALL: req_fifowr=0 while fifo_full. In the first cycle fifo_full==0, req_fifowr=1, then continue.
- After a write or skip: if index==roi_last -> DONE; else index+1 -> SETTLE. Index never wraps past roi_last.
- DONE: frame_done=1 for one cycle and frame_cnt+1, then:
  - single_shot: -> IDLE;
  - continuous: -> CLEAR if en && pll_locked, else -> IDLE.
- en deasserted mid-frame: the frame completes normally, then -> IDLE.
- Zero pad bits of dout are always 0.

Test Plan:
- Defaults, window_cycles=2, roi 0..1023, DIN=5'b10011, spad_on_clk period 100 ns, clk 20 ns -> MEM_CLEAR high 4 cycles; SPAD_ON_CLK_EN spans exactly 2 spad_on_clk rising edges; 1024 writes with dout[15:6]=0..1023, dout[5]=0, dout[4:0]=10011; one frame_done; frame_cnt=1.
- roi_first=10'h005, roi_last=10'h008, skip_zero=1, DIN=0 at index 6 only -> exactly 3 writes with addresses 5, 7, 8.
- fifo_full held high for 10 cycles at the 3rd write -> req_fifowr low for those cycles; next write carries index 2 unchanged; no word lost or duplicated.
- pll_locked dropped during EXPOSE -> SPAD_ON_CLK_EN low next cycle; lock_lost pulse; no req_fifowr; frame_cnt unchanged; busy=0.
- single_shot=1 with en held high -> exactly one frame. Toggle en 0->1 -> a second frame; frame_cnt=2.
- rst asserted mid-scan -> all outputs 0 immediately. After release with en=1, a full frame starts at CLEAR.
